// File: rtl/accum_pkg.sv
// Shared types and default parameters for the accum_lanes block.
package accum_pkg;
    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    localparam int LANES_DEF  = 4;
    localparam int DATAW_DEF  = 19;
    localparam int ACCUMW_DEF = 32;
    localparam int CNTW_DEF   = 16;
endpackage

// File: rtl/accum_lane.sv
// One accumulator lane: load/add mux, optional clamping (ACCUM_LANES_SAT_EN), sat tracking
// and the reported result register.
module accum_lane #(
    parameter int DATAW  = 19,
    parameter int ACCUMW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATAW-1:0]  data,
    input  logic              load,
    input  logic              add,
    input  logic              report,
    output logic [ACCUMW-1:0] result,
    output logic              sat
);
    logic [ACCUMW-1:0] acc;
    logic              sat_run;
    logic [ACCUMW-1:0] data_ext;
    logic [ACCUMW-1:0] add_val;
    logic              add_sat;
    logic [ACCUMW-1:0] next_acc;
    logic              next_sat;

    assign data_ext = ACCUMW'($signed(data));

`ifdef ACCUM_LANES_SAT_EN
    localparam logic [ACCUMW-1:0] MAXV = {1'b0, {(ACCUMW-1){1'b1}}};
    localparam logic [ACCUMW-1:0] MINV = {1'b1, {(ACCUMW-1){1'b0}}};
    logic [ACCUMW:0] sum_ext;

    // One guard bit: overflow shows up as the two top bits disagreeing.
    assign sum_ext = {acc[ACCUMW-1], acc} + {data_ext[ACCUMW-1], data_ext};
    assign add_sat = sum_ext[ACCUMW] ^ sum_ext[ACCUMW-1];
    assign add_val = add_sat ? (sum_ext[ACCUMW] ? MINV : MAXV) : sum_ext[ACCUMW-1:0];
`else
    assign add_val = acc + data_ext;
    assign add_sat = 1'b0;
`endif

    assign next_acc = load ? data_ext : add_val;
    assign next_sat = load ? 1'b0 : (sat_run | add_sat);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            sat_run <= 1'b0;
            result  <= '0;
            sat     <= 1'b0;
        end else begin
            if (load || add) begin
                acc     <= next_acc;
                sat_run <= next_sat;
            end
            if (report) begin
                result <= next_acc;
                sat    <= next_sat;
            end
        end
    end
endmodule

// File: rtl/accum_lanes.sv
// Multi-lane vector accumulator with first/last framing, beat counting and sticky error.
// Optional lane saturation is enabled by defining ACCUM_LANES_SAT_EN.
module accum_lanes
    import accum_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int DATAW  = DATAW_DEF,
    parameter int ACCUMW = ACCUMW_DEF,
    parameter int CNTW   = CNTW_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*DATAW-1:0]  data,
    input  logic                    ivalid,
    input  logic                    first,
    input  logic                    last,
    output logic [LANES*ACCUMW-1:0] result,
    output logic                    ovalid,
    output logic [CNTW-1:0]         count,
    output logic [LANES-1:0]        sat,
    output logic                    err
);
    state_t          state;
    state_t          state_next;
    logic            load;
    logic            add;
    logic            report;
    logic            err_set;
    logic [CNTW-1:0] cnt_run;
    logic [CNTW-1:0] cnt_next;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (ivalid) begin
            if (first)               state_next = last ? IDLE : ACC;
            else if (state == ACC && last) state_next = IDLE;
        end
    end

    // A first beat always restarts, even mid-vector; a headless beat in IDLE is dropped.
    always_comb begin
        load    = ivalid & first;
        add     = ivalid & ~first & (state == ACC);
        report  = ivalid & last & (first | (state == ACC));
        err_set = ivalid & (first ? (state == ACC) : (state == IDLE));
    end

    assign cnt_next = load ? CNTW'(1) : ((&cnt_run) ? cnt_run : cnt_run + CNTW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_run <= '0;
            count   <= '0;
            ovalid  <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (load || add) cnt_run <= cnt_next;
            if (report)      count   <= cnt_next;
            ovalid <= report;
            err    <= err | err_set;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        accum_lane #(
            .DATAW (DATAW),
            .ACCUMW(ACCUMW)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .data  (data[i*DATAW +: DATAW]),
            .load  (load),
            .add   (add),
            .report(report),
            .result(result[i*ACCUMW +: ACCUMW]),
            .sat   (sat[i])
        );
    end
endmodule

// File: tb/tb_accum_lanes.sv
// Bench for accum_lanes: directed scenarios plus random beats against a per-vector arithmetic model.
module tb_accum_lanes;
    localparam int LANES  = 4;
    localparam int DATAW  = 19;
    localparam int ACCUMW = 20;
    localparam int CNTW   = 4;
    localparam longint MAXV = (longint'(1) <<< (ACCUMW-1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (ACCUMW-1));
    localparam longint MODV = longint'(1) <<< ACCUMW;
    localparam int CMAX = (1 << CNTW) - 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [LANES*DATAW-1:0]  data;
    logic                    ivalid;
    logic                    first;
    logic                    last;
    logic [LANES*ACCUMW-1:0] result;
    logic                    ovalid;
    logic [CNTW-1:0]         count;
    logic [LANES-1:0]        sat;
    logic                    err;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: vector-level sums held as plain integers
    longint     m_acc[LANES];
    longint     m_res[LANES];
    int         m_cnt, m_count;
    logic [LANES-1:0] m_satv, m_sat;
    bit         m_in, m_ovalid, m_err;

    always #5 clk = ~clk;

    accum_lanes #(
        .LANES (LANES),
        .DATAW (DATAW),
        .ACCUMW(ACCUMW),
        .CNTW  (CNTW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .data  (data),
        .ivalid(ivalid),
        .first (first),
        .last  (last),
        .result(result),
        .ovalid(ovalid),
        .count (count),
        .sat   (sat),
        .err   (err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [LANES*DATAW-1:0] mk(input longint l0, l1, l2, l3);
        logic [DATAW-1:0] a, b, c, e;
        a = l0[DATAW-1:0]; b = l1[DATAW-1:0]; c = l2[DATAW-1:0]; e = l3[DATAW-1:0];
        return {e, c, b, a};
    endfunction

    function automatic longint lane_val(input logic [LANES*DATAW-1:0] d, input int i);
        logic [DATAW-1:0] x;
        x = d[i*DATAW +: DATAW];
        return longint'($signed(x));
    endfunction

    task automatic report_vec();
        for (int i = 0; i < LANES; i++) m_res[i] = m_acc[i];
        m_count  = m_cnt;
        m_sat    = m_satv;
        m_ovalid = 1'b1;
    endtask

    task automatic model_update(input bit r, v, f, l, input logic [LANES*DATAW-1:0] d);
        longint s;
        m_ovalid = 1'b0;
        if (r) begin
            m_in = 0; m_err = 0; m_cnt = 0; m_count = 0; m_satv = '0; m_sat = '0;
            for (int i = 0; i < LANES; i++) begin m_acc[i] = 0; m_res[i] = 0; end
            return;
        end
        if (!v) return;
        if (f) begin
            if (m_in) m_err = 1'b1;
            for (int i = 0; i < LANES; i++) m_acc[i] = lane_val(d, i);
            m_satv = '0;
            m_cnt  = 1;
            m_in   = !l;
            if (l) report_vec();
        end else if (!m_in) begin
            m_err = 1'b1;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                s = m_acc[i] + lane_val(d, i);
`ifdef ACCUM_LANES_SAT_EN
                if (s > MAXV) begin s = MAXV; m_satv[i] = 1'b1; end
                if (s < MINV) begin s = MINV; m_satv[i] = 1'b1; end
`else
                if (s > MAXV) s = s - MODV;
                if (s < MINV) s = s + MODV;
`endif
                m_acc[i] = s;
            end
            m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            if (l) begin report_vec(); m_in = 0; end
        end
    endtask

    task automatic compare_all();
        check("ovalid", 64'(ovalid), 64'(m_ovalid));
        check("err", 64'(err), 64'(m_err));
        check("count", 64'(count), 64'(m_count));
        check("sat", 64'(sat), 64'(m_sat));
        for (int i = 0; i < LANES; i++) begin
            logic [ACCUMW-1:0] e;
            e = m_res[i][ACCUMW-1:0];
            check($sformatf("result_lane%0d", i), 64'(result[i*ACCUMW +: ACCUMW]), 64'(e));
        end
    endtask

    task automatic step(input bit r, v, f, l, input logic [LANES*DATAW-1:0] d);
        rst = r; ivalid = v; first = f; last = l; data = d;
        @(posedge clk);
        model_update(r, v, f, l, d);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_garbage(input int n);
        logic [95:0] t;
        for (int k = 0; k < n; k++) begin
            t = {$urandom(), $urandom(), $urandom()};
            step(0, 0, t[0], t[1], t[LANES*DATAW+1:2]);
        end
    endtask

    initial begin
        logic [95:0] t;
        bit v, f, l, r;

        step(1, 0, 0, 0, '0);
        step(1, 1, 1, 1, mk(9, 9, 9, 9));
        check("reset_result", 64'(result[ACCUMW-1:0]), 64'd0);
        check("reset_ovalid", 64'(ovalid), 64'd0);
        step(0, 0, 0, 0, '0);

        // three-beat vector, ivalid held high
        step(0, 1, 1, 0, mk(5, 1, 2, 3));
        step(0, 1, 0, 0, mk(-3, 1, 2, 3));
        step(0, 1, 0, 1, mk(10, 1, 2, 3));
        check("r034_lane0", 64'(result[ACCUMW-1:0]), 64'd12);
        check("r034_count", 64'(count), 64'd3);
        step(0, 0, 0, 0, '0);
        check("r034_pulse_end", 64'(ovalid), 64'd0);

        // same vector with two idle (garbage) cycles between beats
        step(0, 1, 1, 0, mk(5, -1, -2, -3));
        idle_garbage(2);
        step(0, 1, 0, 0, mk(-3, -1, -2, -3));
        idle_garbage(2);
        step(0, 1, 0, 1, mk(10, -1, -2, -3));
        check("r035_lane0", 64'(result[ACCUMW-1:0]), 64'd12);
        idle_garbage(3);

        // single-beat vector immediately followed by another vector
        step(0, 1, 1, 1, mk(4, -7, 0, 1));
        check("r036_lane1", 64'(result[ACCUMW +: ACCUMW]), 64'hFFFF9);
        check("r036_count", 64'(count), 64'd1);
        step(0, 1, 1, 0, mk(1, 1, 1, 1));
        step(0, 1, 0, 1, mk(2, 2, 2, 2));
        step(0, 1, 1, 1, mk(-1, -2, -3, -4));

        // lane0 overflow at ACCUMW=20
        step(0, 1, 1, 0, mk(262143, 0, 0, 0));
        step(0, 1, 0, 0, mk(262143, 0, 0, 0));
        step(0, 1, 0, 0, mk(262143, 0, 0, 0));
        step(0, 1, 0, 1, mk(262143, 0, 0, 0));
`ifdef ACCUM_LANES_SAT_EN
        check("r037_lane0", 64'(result[ACCUMW-1:0]), 64'd524287);
        check("r037_sat0", 64'(sat[0]), 64'd1);
`else
        check("r037_lane0", 64'(result[ACCUMW-1:0]), 64'hFFFFC);
        check("r037_sat0", 64'(sat[0]), 64'd0);
`endif

        // count saturation on a long vector
        step(0, 1, 1, 0, mk(1, 2, 3, 4));
        for (int k = 0; k < 18; k++) step(0, 1, 0, 0, mk(1, 2, 3, 4));
        step(0, 1, 0, 1, mk(1, 2, 3, 4));
        check("cnt_saturate", 64'(count), 64'(CMAX));

        // protocol errors: headless beat, then first inside a vector
        step(1, 0, 0, 0, '0);
        step(0, 1, 0, 0, mk(100, 100, 100, 100));
        check("r038_err_headless", 64'(err), 64'd1);
        step(0, 1, 1, 0, mk(1, 1, 1, 1));
        step(0, 1, 1, 0, mk(2, 3, 4, 5));
        step(0, 1, 0, 1, mk(1, 1, 1, 1));
        check("r038_count", 64'(count), 64'd2);
        idle_garbage(4);
        check("r038_err_sticky", 64'(err), 64'd1);

        // reset mid-vector
        step(1, 0, 0, 0, '0);
        step(0, 1, 1, 0, mk(50, 50, 50, 50));
        step(0, 1, 0, 0, mk(60, 60, 60, 60));
        step(1, 1, 0, 1, mk(70, 70, 70, 70));
        check("r039_ovalid", 64'(ovalid), 64'd0);
        check("r039_result", 64'(result), 64'd0);
        step(0, 1, 0, 0, mk(8, 8, 8, 8));
        step(0, 1, 1, 0, mk(3, 3, 3, 3));
        step(0, 1, 0, 1, mk(4, 4, 4, 4));
        check("r039_fresh_lane0", 64'(result[ACCUMW-1:0]), 64'd7);

        // random traffic
        for (int k = 0; k < 1500; k++) begin
            t = {$urandom(), $urandom(), $urandom()};
            v = ($urandom_range(0, 9) < 7);
            f = m_in ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 8);
            l = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 199) == 0);
            step(r, v, f, l, t[LANES*DATAW-1:0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/accum_lanes.md
ACCUM_LANES -- requirements
Module: accum_lanes

Interface
REQ-001 SHALL take parameter LANES, default 4: number of parallel accumulator lanes.
REQ-002 SHALL take parameter DATAW, default 19: signed input width per lane.
REQ-003 SHALL take parameter ACCUMW, default 32: signed accumulator/result width per lane; ACCUMW >= DATAW.
REQ-004 SHALL take parameter CNTW, default 16: beat-counter width.
REQ-005 SHALL have port clk  in  1  the single clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port data  in  LANES*DATAW  packed signed lane inputs; lane i at bits [i*DATAW +: DATAW].
REQ-008 SHALL have port ivalid  in  1  beat valid.
REQ-009 SHALL have port first  in  1  beat is the first of a vector; qualified by ivalid.
REQ-010 SHALL have port last  in  1  beat is the last of a vector; qualified by ivalid.
REQ-011 SHALL have port result  out  LANES*ACCUMW  packed signed lane sums; lane i at bits [i*ACCUMW +: ACCUMW].
REQ-012 SHALL have port ovalid  out  1  single-cycle pulse marking a new result.
REQ-013 SHALL have port count  out  CNTW  number of beats in the reported vector.
REQ-014 SHALL have port sat  out  LANES  per-lane flag: saturation occurred in the reported vector.
REQ-015 SHALL have port err  out  1  sticky protocol-error flag.

Function
REQ-016 SHALL accept a beat only when ivalid=1; with ivalid=0, data/first/last are ignored and no state changes.
REQ-017 SHALL implement FSM states IDLE and ACC.
REQ-018 IDLE, accepted first&~last: each lane acc = sign-extended data, count = 1, go to ACC.
REQ-019 IDLE, accepted first&last: single-beat vector; result = sign-extended data, count = 1, stay IDLE.
REQ-020 IDLE, accepted beat without first: beat dropped, err set, stay IDLE.
REQ-021 ACC, accepted ~first: each lane acc += sign-extended data, count += 1; if last, report and go to IDLE.
REQ-022 ACC, accepted first: set err, discard the partial vector, restart per REQ-018/REQ-019.
REQ-023 SHALL assert ovalid exactly one cycle after the clock edge accepting the last beat, for one cycle; result/count/sat registered at that edge.
REQ-024 SHALL hold result, count and sat stable between reports; they change only when ovalid pulses.
REQ-025 SHALL saturate count at 2**CNTW-1 rather than wrap.
REQ-026 SHALL support back-to-back vectors: first beat of vector N+1 may arrive on the cycle after last of vector N with no bubble.
REQ-027 Lane arithmetic SHALL be two's complement at ACCUMW; overflow behaviour per REQ-030/REQ-031.

Reset
REQ-028 On rst=1 at a clock edge: state IDLE, all accumulators 0, result 0, count 0, sat 0, ovalid 0, err 0.
REQ-029 rst mid-vector SHALL discard the partial vector with no ovalid; rst overrides any simultaneous beat.

Configuration
REQ-030 With macro ACCUM_LANES_SAT_EN defined: each lane clamps to +2**(ACCUMW-1)-1 / -2**(ACCUMW-1) on overflow and sets its sat bit for the current vector.
REQ-031 Without ACCUM_LANES_SAT_EN: lanes wrap modulo 2**ACCUMW and sat is tied to 0.

Structure
REQ-032 Package accum_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-033 One sub-module accum_lane SHALL implement a single lane's accumulator, load/add mux, saturation and sat tracking, instantiated LANES times via generate.

Verification
REQ-034 Lane0 beats 5,-3,10 (first on beat 1, last on beat 3), ivalid held 1 -> one cycle after beat 3: ovalid=1, result lane0=12, count=3.
REQ-035 Same vector with ivalid=0 for 2 cycles between beats -> identical result 12, count=3; ovalid still one cycle after last.
REQ-036 Single beat first=last=1, lane1 data=-7 -> result lane1=-7, count=1; next cycle a new vector starts with no bubble.
REQ-037 DATAW=19, ACCUMW=20, lane0 adds 2**18-1 four times -> ACCUM_LANES_SAT_EN: result 524287, sat[0]=1; without macro: wrapped value -4, sat=0.
REQ-038 Beat without first in IDLE, then first in ACC -> err=1 sticky until rst; dropped beat not counted.
REQ-039 rst asserted after 2 beats of a vector -> no ovalid, all outputs 0, next vector sums from scratch.
